snake_dir_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 19 +
 rtl/key_debounce.sv | 62 ++++++
 rtl/snake_dir_ctrl.sv | 108 ++++++++++
 tb/tb_snake_dir_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake direction input stage and the downstream move FSM.
// Build option DIR_DEBOUNCE_EN selects counter-based key debouncing (see key_debounce).
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_RIGHT = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_UP    = 2'b10;
    localparam dir_t DIR_LEFT  = 2'b11;

    localparam int QDEPTH = 2;

    // Encoding is chosen so the opposite direction is the bitwise complement.
    function automatic dir_t dir_reverse(input dir_t d);
        return ~d;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, debounced state and a one-cycle press pulse.
// With DIR_DEBOUNCE_EN defined a stability counter filters bounces; otherwise the synced level is used directly.
module key_debounce #(
    parameter int DB_MAX = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_b_i,
    output logic press_o
);

    logic [1:0] sync_q;
    logic       db_q;
    logic       db_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
            db_q   <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], key_b_i};
            db_q   <= db_d;
        end
    end

`ifdef DIR_DEBOUNCE_EN
    logic [19:0] cnt_q;
    logic [19:0] cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync_q[1] == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == 20'(DB_MAX - 1)) begin
            db_d  = ~db_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end
    end
`else
    logic unused_db_max;
    assign unused_db_max = ^DB_MAX;

    always_comb begin
        db_d = sync_q[1];
    end
`endif

    // Released (1) to pressed (0) only; the release edge is deliberately ignored.
    assign press_o = db_q & ~db_d;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake input stage: debounced keys -> validated turn queue (depth 2) -> current dir, plus step pacing.
// Build option DIR_DEBOUNCE_EN enables the debounce counters inside key_debounce.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int DB_MAX = 1000000,
    parameter int STEP_K = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        key_i,
    input  logic              pause_i,
    input  logic              advance_i,
    output dir_t              dir_o,
    output logic              moving_o,
    output logic              step_o,
    output logic [1:0]        qcount_o
);

    logic [3:0]        press;
    dir_t              dir_q, dir_d;
    dir_t              head_q, head_d;
    dir_t              next_q, next_d;
    logic [1:0]        qcnt_q, qcnt_d;
    logic              moving_q, moving_d;
    logic [STEP_K-1:0] step_q, step_d;

    dir_t              ev_dir;
    dir_t              tail;
    logic              ev_vld;
    logic              accept;
    logic              pop;
    logic              push;
    logic [1:0]        cnt_mid;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(.DB_MAX(DB_MAX)) u_key (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .key_b_i (key_i[i]),
            .press_o (press[i])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dir_q    <= DIR_RIGHT;
            head_q   <= DIR_RIGHT;
            next_q   <= DIR_RIGHT;
            qcnt_q   <= 2'd0;
            moving_q <= 1'b0;
            step_q   <= '0;
        end else begin
            dir_q    <= dir_d;
            head_q   <= head_d;
            next_q   <= next_d;
            qcnt_q   <= qcnt_d;
            moving_q <= moving_d;
            step_q   <= step_d;
        end
    end

    // Key index doubles as the direction code, lowest index wins.
    always_comb begin
        ev_vld = |press;
        if (press[0])      ev_dir = DIR_RIGHT;
        else if (press[1]) ev_dir = DIR_DOWN;
        else if (press[2]) ev_dir = DIR_UP;
        else               ev_dir = DIR_LEFT;
    end

    always_comb begin
        if (qcnt_q == 2'd0)      tail = dir_q;
        else if (qcnt_q == 2'd1) tail = head_q;
        else                     tail = next_q;

        accept = ev_vld && (!moving_q || (ev_dir != tail && ev_dir != dir_reverse(tail)));
        pop    = advance_i && (qcnt_q != 2'd0);
        push   = accept && ((qcnt_q != 2'(QDEPTH)) || pop);
    end

    // Pop first, then push into the slot just past the surviving entries.
    always_comb begin
        dir_d   = dir_q;
        head_d  = head_q;
        next_d  = next_q;
        cnt_mid = qcnt_q;
        if (pop) begin
            dir_d   = head_q;
            head_d  = next_q;
            cnt_mid = qcnt_q - 2'd1;
        end
        qcnt_d = cnt_mid;
        if (push) begin
            if (cnt_mid == 2'd0) head_d = ev_dir;
            else                 next_d = ev_dir;
            qcnt_d = cnt_mid + 2'd1;
        end
        moving_d = moving_q | push;
        step_d   = pause_i ? step_q : step_q + 1'b1;
    end

    assign dir_o    = dir_q;
    assign moving_o = moving_q;
    assign qcount_o = qcnt_q;
    assign step_o   = (&step_q) & ~pause_i;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Scoreboard bench for snake_dir_ctrl with DB_MAX=4, STEP_K=3; works with or without DIR_DEBOUNCE_EN.
module tb_snake_dir_ctrl;
    import snake_pkg::*;

    localparam int DB_MAX = 4;
    localparam int STEP_K = 3;
`ifdef DIR_DEBOUNCE_EN
    localparam int LAT = DB_MAX + 2;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic       pause = 1'b0;
    logic       advance = 1'b0;
    dir_t       dir;
    logic       moving;
    logic       step;
    logic [1:0] qcount;

    snake_dir_ctrl #(.DB_MAX(DB_MAX), .STEP_K(STEP_K)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .key_i     (key),
        .pause_i   (pause),
        .advance_i (advance),
        .dir_o     (dir),
        .moving_o  (moving),
        .step_o    (step),
        .qcount_o  (qcount)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    int         step_exp[$];
    bit         step_en = 1'b0;
    logic [4:0] st_exp[$];
    string      st_tag[$];

    always @(negedge clk) begin
        if (step_en && !rst && step === 1'b1) begin
            if (step_exp.size() == 0) chk("step_extra", {31'd0, step}, 32'd0);
            else                      chk("step_cycle", cyc, step_exp.pop_front());
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        key = 4'hF;
        pause = 1'b0;
        advance = 1'b0;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        key = ~mask;
        cycles(hold);
        key = 4'hF;
        cycles(12);
    endtask

    task automatic press_adv(input logic [3:0] mask);
        key = ~mask;
        cycles(LAT - 1);
        advance = 1'b1;
        cycles(1);
        advance = 1'b0;
        cycles(10 - LAT);
        key = 4'hF;
        cycles(12);
    endtask

    task automatic pulse_adv();
        advance = 1'b1;
        cycles(1);
        advance = 1'b0;
        cycles(2);
    endtask

    task automatic expect_st(input string tag, input logic [1:0] q, input dir_t d, input logic m);
        st_exp.push_back({q, d, m});
        st_tag.push_back(tag);
    endtask

    task automatic compare_st();
        logic [4:0] e;
        string      t;
        while (st_exp.size() > 0) begin
            e = st_exp.pop_front();
            t = st_tag.pop_front();
            chk({t, "_qcount"}, {30'd0, qcount}, {30'd0, e[4:3]});
            chk({t, "_dir"},    {30'd0, dir},    {30'd0, e[2:1]});
            chk({t, "_moving"}, {31'd0, moving}, {31'd0, e[0]});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        expect_st("reset", 2'd0, DIR_RIGHT, 1'b0);
        compare_st();
        chk("reset_step", {31'd0, step}, 32'd0);

        step_exp = '{7, 15, 23};
        step_en = 1'b1;
        cycles(28);
        step_en = 1'b0;
        chk("step_missing", step_exp.size(), 32'd0);

        // Short glitch: filtered only when the debounce counters are built in.
        press(4'b0010, 3);
`ifdef DIR_DEBOUNCE_EN
        expect_st("glitch", 2'd0, DIR_RIGHT, 1'b0);
`else
        expect_st("glitch", 2'd1, DIR_RIGHT, 1'b1);
`endif
        compare_st();
        do_reset();

        press(4'b0010, 10);
        expect_st("hold_down", 2'd1, DIR_RIGHT, 1'b1);
        compare_st();
        pulse_adv();
        expect_st("adv_down", 2'd0, DIR_DOWN, 1'b1);
        compare_st();

        do_reset();
        press(4'b0001, 10);
        expect_st("first_right", 2'd1, DIR_RIGHT, 1'b1);
        compare_st();
        pulse_adv();
        expect_st("adv_right", 2'd0, DIR_RIGHT, 1'b1);
        compare_st();
        press(4'b1000, 10);
        expect_st("reverse_left", 2'd0, DIR_RIGHT, 1'b1);
        compare_st();
        press(4'b0010, 10);
        expect_st("q_down", 2'd1, DIR_RIGHT, 1'b1);
        compare_st();
        press(4'b1000, 10);
        expect_st("q_left", 2'd2, DIR_RIGHT, 1'b1);
        compare_st();
        pulse_adv();
        expect_st("pop1", 2'd1, DIR_DOWN, 1'b1);
        compare_st();
        pulse_adv();
        expect_st("pop2", 2'd0, DIR_LEFT, 1'b1);
        compare_st();

        press(4'b0100, 10);
        expect_st("fill_up", 2'd1, DIR_LEFT, 1'b1);
        compare_st();
        press(4'b0001, 10);
        expect_st("fill_right", 2'd2, DIR_LEFT, 1'b1);
        compare_st();
        press(4'b0010, 10);
        expect_st("full_drop", 2'd2, DIR_LEFT, 1'b1);
        compare_st();
        pulse_adv();
        expect_st("drop_pop1", 2'd1, DIR_UP, 1'b1);
        compare_st();
        pulse_adv();
        expect_st("drop_pop2", 2'd0, DIR_RIGHT, 1'b1);
        compare_st();
        pulse_adv();
        expect_st("adv_empty", 2'd0, DIR_RIGHT, 1'b1);
        compare_st();

        press(4'b0010, 10);
        press(4'b1000, 10);
        expect_st("refill", 2'd2, DIR_RIGHT, 1'b1);
        compare_st();
        press_adv(4'b0100);
        expect_st("push_pop_full", 2'd2, DIR_DOWN, 1'b1);
        compare_st();
        pulse_adv();
        expect_st("order1", 2'd1, DIR_LEFT, 1'b1);
        compare_st();
        pulse_adv();
        expect_st("order2", 2'd0, DIR_UP, 1'b1);
        compare_st();

        do_reset();
        press(4'b0101, 10);
        expect_st("simul", 2'd1, DIR_RIGHT, 1'b1);
        compare_st();
        pulse_adv();
        expect_st("simul_pop", 2'd0, DIR_RIGHT, 1'b1);
        compare_st();

        do_reset();
        step_exp = '{27, 35};
        step_en = 1'b1;
        cycles(3);
        pause = 1'b1;
        cycles(20);
        pause = 1'b0;
        cycles(14);
        step_en = 1'b0;
        chk("pause_step_missing", step_exp.size(), 32'd0);
        cycles(6);
        chk("step_at_ones", {31'd0, step}, 32'd1);
        pause = 1'b1;
        #1;
        chk("pause_masks_step", {31'd0, step}, 32'd0);
        @(negedge clk);
        pause = 1'b0;

        do_reset();
        press(4'b0010, 10);
        press(4'b0001, 10);
        expect_st("pre_reset", 2'd2, DIR_RIGHT, 1'b1);
        compare_st();
        #2;
        rst = 1'b1;
        #1;
        expect_st("async_reset", 2'd0, DIR_RIGHT, 1'b0);
        compare_st();
        chk("async_reset_step", {31'd0, step}, 32'd0);
        cycles(2);
        rst = 1'b0;
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
